bus_arb2: RTL and testbench
===========================

# bus_arb2

Two-requester bus arbiter and output register that feeds the shared 8-bit bus. It grants one of two sources in round-robin bursts, drives the `sel` of the `Mux8` data selector, and registers the selected word onto `bus1` with a valid/ready handshake toward the downstream consumer. It sits directly upstream of the bus consumer and owns the `Mux8` select line.

## Interface
Parameters:
- `DW`, 8, data width of each source and of `bus1`.
- `MAX_BURST`, 4, maximum accepted beats per grant before a forced release; must be ≥1.

Ports (clock `clk`, reset `rst`; one clock; reset asynchronous, active-high):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` in 1: source 0 has a word on `data0`.
- `data0` in DW: source 0 word.
- `ack0` out 1: source 0 word accepted this cycle (combinational).
- `req1` in 1: source 1 has a word on `data1`.
- `data1` in DW: source 1 word.
- `ack1` out 1: source 1 word accepted this cycle (combinational).
- `sel` out 1: current grant, 0 = source 0, 1 = source 1; drives the `Mux8` select.
- `bus1` out DW: registered output word.
- `bus_valid` out 1: `bus1` holds an undelivered word.
- `bus_ready` in 1: downstream accepts `bus1` this cycle.

## Operation
- FSM states: IDLE, GRANT0, GRANT1. `sel` = 1 only in GRANT1; it is 0 in IDLE and GRANT0.
- IDLE: if any req is high, go to GRANTx on the next edge.
  - Single request: that source is granted.
  - Both requesting: the source not granted last wins. The last-grant pointer resets to 1, so source 0 wins first.
- Output slot free: `free = !bus_valid || bus_ready`.
- Accept: `ackx = (state==GRANTx) && reqx && free`.
  - On accept, `bus1 <= Mux8 output` (the `datax` selected via `sel`), `bus_valid <= 1`, and the beat counter increments.
- When `bus_valid && bus_ready` and there is no accept, `bus_valid <= 0`.
- Stall: while `bus_valid && !bus_ready`, `bus1` holds, `bus_valid` holds, and there is no ack.
- Release from GRANTx occurs on the edge where either:
  - the counter reaches `MAX_BURST` with this cycle's accept, or
  - `reqx` is low.
- On release:
  - The counter clears and the last-grant pointer becomes x.
  - Next state is GRANTy if `reqy` is high, else GRANTx if `reqx` is high (burst limit reached with no competitor), else IDLE.
- Counter width is `$clog2(MAX_BURST+1)`. It never exceeds `MAX_BURST` and never wraps.

## Timing
- Reset values: state IDLE, `sel`=0, `bus1`=0, `bus_valid`=0, `ack0`=`ack1`=0, counter 0, last-grant pointer 1.
- Request-to-grant: 1 cycle from IDLE. When both sources stream, the GRANTx→GRANTy handover costs no idle cycle.
- Accept-to-bus: `bus1`/`bus_valid` update on the edge that ends the ack cycle (latency 1).
- Throughput: 1 beat per cycle while `bus_ready` stays high.
- Simultaneous delivery and accept in the same cycle: `bus_valid` stays 1 and `bus1` takes the new word.
- Source dropping `req` mid-burst: that cycle has no ack, and release happens on that edge.
- Reset mid-operation: all state clears immediately. An undelivered `bus1` word is discarded.

## Configuration
- `BUS_ARB2_FIXED_PRIO_EN` defined: fixed priority.
  - Source 0 wins every simultaneous request.
  - On source 1 burst-limit release with `req0` high, the grant goes to source 0.
  - On source 0 burst-limit release with `req0` still high, source 0 is regranted. Source 1 may starve; this is by design.
- Not defined: round-robin as described in Operation.

## Structure
- Shared package `bus_pkg`: state enum `arb_state_t` {IDLE, GRANT0, GRANT1} and the default `DW`=8 constant.
- Sub-module: one instance of `Mux8` for the data select. `bus_arb2` contains only the FSM, the counter, the pointer and the output register.

## Test plan
- Reset: assert `rst` mid-stream with `bus_valid`=1 → all outputs 0 immediately, state IDLE.
- `req0`=1 streaming 0x11,0x12,…, `bus_ready`=1, `MAX_BURST`=4 → four acks, `bus1` shows 0x11..0x14 one cycle after each ack, then `sel` stays 0 and streaming continues (no competitor).
- Both req from IDLE after reset, `data0`=0xA0, `data1`=0xB0 → GRANT0 first. After 4 beats, `sel`=1 and `bus1`=0xB0 appears with no bubble. The groups alternate 4/4.
- `bus_ready`=0 for 3 cycles with `bus1`=0x55 → `bus1` and `bus_valid` hold and `ack0`=0; resumes the cycle `bus_ready` returns.
- `req1` drops after 2 beats while `req0`=1 → release on that edge, GRANT0 next cycle, counter restarts.
- With `BUS_ARB2_FIXED_PRIO_EN`: both req continuous → source 0 always granted, `ack1` never asserts.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the two-source bus arbiter: FSM state encoding, default
// data width and the grant-selection helper used by bus_arb2.
package bus_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Grant choice given the live requests; prefer1 breaks a tie toward source 1.
  function automatic arb_state_t arb_pick(input logic r0, input logic r1,
                                          input logic prefer1);
    if (r0 && r1) return prefer1 ? GRANT1 : GRANT0;
    if (r0)       return GRANT0;
    if (r1)       return GRANT1;
    return IDLE;
  endfunction

endpackage

// File: rtl/bus_arb2_mux8.sv
// Two-way data selector feeding the bus output register.
module Mux8 #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          sel_i,
  output logic [DW-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/bus_arb2.sv
// Two-requester bus arbiter with burst-limited grants and a registered
// valid/ready output. Define BUS_ARB2_FIXED_PRIO_EN for fixed priority to source 0.
module bus_arb2
  import bus_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          ack1,
  output logic          sel,
  output logic [DW-1:0] bus1,
  output logic          bus_valid,
  input  logic          bus_ready
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

`ifdef BUS_ARB2_FIXED_PRIO_EN
  localparam logic ROUND_ROBIN = 1'b0;
`else
  localparam logic ROUND_ROBIN = 1'b1;
`endif

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [DW-1:0] bus_q, bus_d;
  logic          vld_q, vld_d;

  logic          free, acc, cur_req, release_now;
  logic [DW-1:0] mux_y;

  Mux8 #(.DW(DW)) u_mux (
    .a_i   (data0),
    .b_i   (data1),
    .sel_i (sel),
    .y_o   (mux_y)
  );

  assign free        = !vld_q || bus_ready;
  assign acc         = ack0 || ack1;
  assign cur_req     = (state_q == GRANT1) ? req1 : req0;
  assign release_now = !cur_req || (acc && (cnt_q == LAST_BEAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Tie-break always favours the source other than the new last-grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: state_d = arb_pick(req0, req1, ROUND_ROBIN & !last_q);
      GRANT0, GRANT1: begin
        if (release_now) begin
          cnt_d   = '0;
          last_d  = (state_q == GRANT1);
          state_d = arb_pick(req0, req1, ROUND_ROBIN & (state_q == GRANT0));
        end else begin
          cnt_d = cnt_q + CW'(acc);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel  = (state_q == GRANT1);
    ack0 = (state_q == GRANT0) && req0 && free;
    ack1 = (state_q == GRANT1) && req1 && free;
  end

  always_comb begin
    bus_d = bus_q;
    vld_d = vld_q;
    if (acc) begin
      bus_d = mux_y;
      vld_d = 1'b1;
    end else if (vld_q && bus_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= 1'b1;
      bus_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      bus_q  <= bus_d;
      vld_q  <= vld_d;
    end
  end

  assign bus1      = bus_q;
  assign bus_valid = vld_q;

endmodule

// File: tb/tb_bus_arb2.sv
module tb_bus_arb2;

`ifdef BUS_ARB2_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, bus_ready = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, sel, bus_valid;
  logic [7:0] bus1;

  bus_arb2 #(.DW(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .ack1      (ack1),
    .sel       (sel),
    .bus1      (bus1),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, req0;
    logic [7:0] d0;
    logic       req1;
    logic [7:0] d1;
    logic       rdy;
    logic       ack0, ack1, sel;
    logic [7:0] bus;
    logic       vld;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input string nm, input logic r, input logic q0,
                              input logic [7:0] d0, input logic q1,
                              input logic [7:0] d1, input logic rdy,
                              input logic a0, input logic a1, input logic s,
                              input logic [7:0] b, input logic v);
    vec_t t;
    t.name = nm; t.rst = r; t.req0 = q0; t.d0 = d0; t.req1 = q1; t.d1 = d1;
    t.rdy = rdy; t.ack0 = a0; t.ack1 = a1; t.sel = s; t.bus = b; t.vld = v;
    return t;
  endfunction

  initial begin
    logic [11:0] got, exp;
    int g, pg;
    logic [7:0] eb;
    bit seen;

    tbl.push_back(mk("a_rst",  1,0,8'h00,0,8'h00,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("a_idle", 0,1,8'h11,0,8'h00,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("a_b1",   0,1,8'h11,0,8'h00,1, 1,0,0,8'h00,0));
    tbl.push_back(mk("a_b2",   0,1,8'h12,0,8'h00,1, 1,0,0,8'h11,1));
    tbl.push_back(mk("a_b3",   0,1,8'h13,0,8'h00,1, 1,0,0,8'h12,1));
    tbl.push_back(mk("a_b4",   0,1,8'h14,0,8'h00,1, 1,0,0,8'h13,1));
    tbl.push_back(mk("a_b5",   0,1,8'h15,0,8'h00,1, 1,0,0,8'h14,1));
    tbl.push_back(mk("a_drop", 0,0,8'h00,0,8'h00,1, 0,0,0,8'h15,1));
    tbl.push_back(mk("a_done", 0,0,8'h00,0,8'h00,1, 0,0,0,8'h15,0));
    tbl.push_back(mk("c_rst",  1,0,8'h00,0,8'h00,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("c_idle", 0,1,8'h55,0,8'h00,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("c_b1",   0,1,8'h55,0,8'h00,1, 1,0,0,8'h00,0));
    tbl.push_back(mk("c_st1",  0,1,8'h56,0,8'h00,0, 0,0,0,8'h55,1));
    tbl.push_back(mk("c_st2",  0,1,8'h56,0,8'h00,0, 0,0,0,8'h55,1));
    tbl.push_back(mk("c_st3",  0,1,8'h56,0,8'h00,0, 0,0,0,8'h55,1));
    tbl.push_back(mk("c_res",  0,1,8'h56,0,8'h00,1, 1,0,0,8'h55,1));
    tbl.push_back(mk("c_b3",   0,1,8'h57,0,8'h00,1, 1,0,0,8'h56,1));
    tbl.push_back(mk("c_arst", 1,1,8'h58,0,8'h00,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("c_post", 0,0,8'h00,0,8'h00,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("d_rst",  1,0,8'h00,0,8'h00,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("d_idle", 0,0,8'h00,1,8'hC0,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("d_g1a",  0,1,8'hD0,1,8'hC0,1, 0,1,1,8'h00,0));
    tbl.push_back(mk("d_g1b",  0,1,8'hD0,1,8'hC1,1, 0,1,1,8'hC0,1));
    tbl.push_back(mk("d_drop", 0,1,8'hD0,0,8'h00,1, 0,0,1,8'hC1,1));
    tbl.push_back(mk("d_g0a",  0,1,8'hD0,0,8'h00,1, 1,0,0,8'hC1,0));
    tbl.push_back(mk("d_g0b",  0,1,8'hD1,0,8'h00,1, 1,0,0,8'hD0,1));
    tbl.push_back(mk("d_g0c",  0,1,8'hD2,0,8'h00,1, 1,0,0,8'hD1,1));
    tbl.push_back(mk("d_g0d",  0,1,8'hD3,0,8'h00,1, 1,0,0,8'hD2,1));
    tbl.push_back(mk("d_end",  0,0,8'h00,0,8'h00,1, 0,0,0,8'hD3,1));
    tbl.push_back(mk("b_rst",  1,0,8'h00,0,8'h00,1, 0,0,0,8'h00,0));
    tbl.push_back(mk("b_idle", 0,1,8'hA0,1,8'hB0,1, 0,0,0,8'h00,0));
    pg = 0;
    for (int k = 0; k < 12; k++) begin
      g  = FIXED ? 0 : (k / 4) % 2;
      eb = (k == 0) ? 8'h00 : (pg == 1 ? 8'(8'hB0 + k - 1) : 8'(8'hA0 + k - 1));
      tbl.push_back(mk($sformatf("b_k%0d", k), 0, 1, 8'(8'hA0 + k), 1,
                       8'(8'hB0 + k), 1, g == 0, g == 1, g == 1, eb, k > 0));
      pg = g;
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; req0 = tbl[i].req0; data0 = tbl[i].d0;
      req1 = tbl[i].req1; data1 = tbl[i].d1; bus_ready = tbl[i].rdy;
      #1;
      got = {ack0, ack1, sel, bus1, bus_valid};
      exp = {tbl[i].ack0, tbl[i].ack1, tbl[i].sel, tbl[i].bus, tbl[i].vld};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s: got ack0=%b ack1=%b sel=%b bus1=%h vld=%b, want ack0=%b ack1=%b sel=%b bus1=%h vld=%b",
                 tbl[i].name, ack0, ack1, sel, bus1, bus_valid,
                 tbl[i].ack0, tbl[i].ack1, tbl[i].sel, tbl[i].bus, tbl[i].vld);
      end
    end

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ack0, ack1, sel, bus1, bus_valid} !== 12'h000) begin
      failures++;
      $display("FAIL async_rst: ack0=%b ack1=%b sel=%b bus1=%h vld=%b not cleared",
               ack0, ack1, sel, bus1, bus_valid);
    end

    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; data0 = 8'h77; req1 = 1'b0; bus_ready = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      @(negedge clk);
      #1;
      if (ack0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_ack0: timeout waiting for ack0 after reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
